mux4_bus_arbiter: RTL and testbench
===================================

// Module: mux4_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one N-bit 4:1 datapath mux (mux4t1_N) among four requesters.
//  Grants one requester at a time and drives the registered 2-bit mux select.
//  Holds the grant until the resource signals completion; a watchdog forces release of a hung owner.
//  Sits beside the shared mux in the pipeline; the mux itself is instantiated by the parent.
// PARAMETERS
//  TIMEOUT  16  max cycles a grant may be held without i_Done; 0 disables the watchdog
//  CNT_W    8   width of watchdog counter; must satisfy TIMEOUT <= 2**CNT_W-1
// PORTS
//  i_CLK      in   1  clock, all state updates on rising edge
//  i_RST      in   1  synchronous reset, active-high
//  i_Req      in   4  request per requester; held high until granted transfer completes
//  i_Done     in   1  shared resource finished current owner's transfer (1-cycle pulse)
//  o_Gnt      out  4  one-hot grant, registered; all-zero when idle
//  o_Sel      out  2  registered mux select = index of current/last owner
//  o_Valid    out  1  a grant is active (== |o_Gnt)
//  o_Timeout  out  1  1-cycle pulse: grant forcibly revoked by watchdog
// BEHAVIOUR
//  Reset: state=IDLE, o_Gnt=0, o_Sel=0, o_Valid=0, o_Timeout=0, ptr=0, cnt=0.
//  Reset mid-grant: all of the above on the next edge; no o_Timeout pulse.
//  FSM: IDLE, BUSY.
//   IDLE: if |i_Req -> pick first set bit scanning ptr, ptr+1, ... (mod 4);
//         next edge: BUSY, o_Gnt=onehot(pick), o_Sel=pick, cnt=0. Req->grant latency 1 cycle.
//         i_Done in IDLE ignored.
//   BUSY: cnt increments each cycle (saturating). Release when any of:
//         (a) i_Done=1; (b) i_Req[o_Sel]=0 (owner abandoned); (c) TIMEOUT!=0 and cnt==TIMEOUT-1.
//         On release: ptr=o_Sel+1 (mod 4, wraps 3->0); o_Timeout=1 next cycle only for (c) alone.
//         If other requests pending at release (owner's bit masked), grant next winner on same
//         edge (zero-bubble hand-off, BUSY stays); else -> IDLE, o_Gnt=0.
//  Priority at release edge: i_Done / abandon beat timeout (no pulse if coincident).
//  Releasing owner's own bit is excluded from that edge's pick; it can win again a later cycle.
//  o_Sel holds last owner's index while IDLE (keeps mux output stable); o_Valid = |o_Gnt.
//  Invariant: o_Gnt is zero or one-hot at all times; never changes while BUSY without release.
// STRUCTURE
//  Shared package mux4_arb_pkg: NREQ=4, SEL_W=2, state encodings ST_IDLE/ST_BUSY.
//  Sub-module rr_pick4: combinational rotating priority encoder
//   (in: req[3:0], ptr[1:0]; out: idx[1:0], any). Used for both IDLE pick and hand-off.
//  Top: FSM + ptr/cnt registers + output registers; no datapath, mux stays in parent.
// TESTING
//  1 Reset then i_Req=4'b0101, ptr=0 -> cycle+1 o_Gnt=0001, o_Sel=0, o_Valid=1.
//  2 Owner 0 gets i_Done with i_Req=0101 still -> next edge o_Gnt=0100, o_Sel=2, no idle cycle.
//  3 Wrap: owner 3 done, i_Req=1011 -> next owner 0 (ptr wrapped to 0), then 1, then 3.
//  4 TIMEOUT=16, owner holds w/o i_Done -> release on 16th grant cycle, o_Timeout high 1 cycle,
//    o_Gnt=0 if no others; i_Done on that same cycle -> release, o_Timeout stays 0.
//  5 Owner drops i_Req mid-grant -> released next edge, treated as done, no timeout pulse.
//  6 i_RST asserted while BUSY -> next edge o_Gnt=0, o_Sel=0, o_Valid=0; first pick from req 0.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter.
//   NREQ     : number of requesters sharing the mux
//   SEL_W    : width of the mux select / requester index
//   state_t  : arbiter FSM states (ST_IDLE, ST_BUSY)
//   onehot4  : index -> one-hot grant vector
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder.
//   i_Req [3:0] : candidate requests
//   i_Ptr [1:0] : index with highest priority this cycle
//   o_Idx [1:0] : first set request scanning i_Ptr, i_Ptr+1, ... (mod 4)
//   o_Any       : at least one request is set (o_Idx meaningless otherwise)
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  i_Req,
  input  logic [SEL_W-1:0] i_Ptr,
  output logic [SEL_W-1:0] o_Idx,
  output logic             o_Any
);

  // Scan from lowest priority to highest so the last hit wins.
  always_comb begin
    o_Any = |i_Req;
    o_Idx = i_Ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_Req[i_Ptr + SEL_W'(k)]) o_Idx = i_Ptr + SEL_W'(k);
    end
  end

endmodule

// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 datapath mux.
// Grants one requester at a time, holds the grant until i_Done, owner
// abandonment, or watchdog expiry, and hands off with no idle bubble.
//   i_CLK      : clock
//   i_RST      : synchronous reset, active-high
//   i_Req[3:0] : per-requester request, held until its transfer completes
//   i_Done     : current owner's transfer finished (1-cycle pulse)
//   o_Gnt[3:0] : registered one-hot grant, zero when idle
//   o_Sel[1:0] : registered mux select, keeps last owner while idle
//   o_Valid    : a grant is active
//   o_Timeout  : 1-cycle pulse when the watchdog revoked a grant
module mux4_bus_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [NREQ-1:0]  i_Req,
  input  logic             i_Done,
  output logic [NREQ-1:0]  o_Gnt,
  output logic [SEL_W-1:0] o_Sel,
  output logic             o_Valid,
  output logic             o_Timeout
);

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t             r_state, w_state_nxt;
  logic [NREQ-1:0]    r_gnt,   w_gnt_nxt;
  logic [SEL_W-1:0]   r_sel,   w_sel_nxt;
  logic [SEL_W-1:0]   r_ptr,   w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_tout,  w_tout_nxt;

  logic               w_busy;
  logic               w_rel_done;
  logic               w_rel_to;
  logic               w_release;
  logic [NREQ-1:0]    w_pick_req;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_any;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_rel_done = w_busy && (i_Done || !i_Req[r_sel]);
  assign w_rel_to   = w_busy && TO_EN && (r_cnt == TO_LAST);
  assign w_release  = w_rel_done || w_rel_to;

  // While busy the only pick that matters is the hand-off one: the releasing
  // owner is masked and the scan starts just past it (the new ptr value).
  assign w_pick_req = w_busy ? (i_Req & ~r_gnt) : i_Req;
  assign w_pick_ptr = w_busy ? (r_sel + SEL_W'(1)) : r_ptr;

  rr_pick4 u_pick (
    .i_Req (w_pick_req),
    .i_Ptr (w_pick_ptr),
    .o_Idx (w_pick_idx),
    .o_Any (w_pick_any)
  );

  // State register
  always_ff @(posedge i_CLK) begin
    if (i_RST) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_any) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_release && !w_pick_any) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / counter next values
  always_comb begin
    w_gnt_nxt  = r_gnt;
    w_sel_nxt  = r_sel;
    w_ptr_nxt  = r_ptr;
    w_cnt_nxt  = r_cnt;
    w_tout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt = onehot4(w_pick_idx);
          w_sel_nxt = w_pick_idx;
          w_cnt_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_ptr_nxt  = w_pick_ptr;
          // Done/abandon take precedence: no pulse when coincident.
          w_tout_nxt = w_rel_to && !w_rel_done;
          if (w_pick_any) begin
            w_gnt_nxt = onehot4(w_pick_idx);
            w_sel_nxt = w_pick_idx;
            w_cnt_nxt = '0;
          end else begin
            w_gnt_nxt = '0;
          end
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_gnt  <= '0;
      r_sel  <= '0;
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_tout <= 1'b0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_sel  <= w_sel_nxt;
      r_ptr  <= w_ptr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_tout <= w_tout_nxt;
    end
  end

  assign o_Gnt     = r_gnt;
  assign o_Sel     = r_sel;
  assign o_Valid   = |r_gnt;
  assign o_Timeout = r_tout;

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Self-checking bench for mux4_bus_arbiter: directed scenarios followed by
// randomized request/done/reset traffic, all compared against a
// transaction-level model of the round-robin rules.
module tb_mux4_bus_arbiter;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       tout;

  always #5 clk = ~clk;

  mux4_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_Req     (req),
    .i_Done    (done),
    .o_Gnt     (gnt),
    .o_Sel     (sel),
    .o_Valid   (valid),
    .o_Timeout (tout)
  );

  // Reference model: owner index (-1 = idle), cycles the grant has been held.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tout  = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit by_done, by_to;
    logic [3:0] others;
    int nxt;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_tout = 1'b0;
    end else if (m_owner < 0) begin
      m_tout = 1'b0;
      nxt = first_from(req, m_ptr);
      if (nxt >= 0) begin
        m_owner = nxt; m_sel = nxt; m_held = 0;
      end
    end else begin
      by_done = done || !req[m_owner];
      by_to   = (TO != 0) && (m_held + 1 == TO);
      if (by_done || by_to) begin
        m_ptr  = (m_owner + 1) % 4;
        m_tout = by_to && !by_done;
        others = req & ~(4'b1 << m_owner);
        nxt    = first_from(others, m_ptr);
        if (nxt >= 0) begin
          m_owner = nxt; m_sel = nxt; m_held = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
        m_tout = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic d, input logic rs);
    logic [3:0] exp_gnt;
    @(negedge clk);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
    check_eq("gnt",   32'(gnt),   32'(exp_gnt));
    check_eq("sel",   32'(sel),   32'(m_sel));
    check_eq("valid", 32'(valid), 32'(m_owner >= 0));
    check_eq("tout",  32'(tout),  32'(m_tout));
  endtask

  initial begin
    logic [3:0] cur;
    int phase;

    // 1: reset, then 0101 -> requester 0 granted one cycle later
    cyc(4'b0000, 1'b0, 1'b1);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_sel", 32'(sel), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_tout", 32'(tout), 32'h0);
    cyc(4'b0101, 1'b0, 1'b0);
    check_eq("t1_gnt", 32'(gnt), 32'h1);
    check_eq("t1_valid", 32'(valid), 32'h1);
    // 2: done with 0101 still up -> zero-bubble hand-off to 2
    cyc(4'b0101, 1'b1, 1'b0);
    check_eq("t2_gnt", 32'(gnt), 32'h4);
    check_eq("t2_sel", 32'(sel), 32'h2);

    // 3: wrap from owner 3 -> 0 -> 1 -> 3
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0);
    check_eq("t3_own3", 32'(gnt), 32'h8);
    cyc(4'b1011, 1'b1, 1'b0);
    check_eq("t3_wrap0", 32'(gnt), 32'h1);
    cyc(4'b1011, 1'b1, 1'b0);
    check_eq("t3_next1", 32'(gnt), 32'h2);
    cyc(4'b1011, 1'b1, 1'b0);
    check_eq("t3_next3", 32'(gnt), 32'h8);

    // 4a: watchdog expiry on the 16th grant cycle
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc(4'b0001, 1'b0, 1'b0);
    check_eq("t4_held", 32'(gnt), 32'h1);
    cyc(4'b0001, 1'b0, 1'b0);
    check_eq("t4_to_gnt", 32'(gnt), 32'h0);
    check_eq("t4_to_pulse", 32'(tout), 32'h1);
    cyc(4'b0000, 1'b0, 1'b0);
    check_eq("t4_pulse_end", 32'(tout), 32'h0);
    // 4b: i_Done on the expiry cycle suppresses the pulse
    cyc(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0);
    check_eq("t4_coinc_gnt", 32'(gnt), 32'h0);
    check_eq("t4_coinc_pulse", 32'(tout), 32'h0);

    // 5: owner abandons its request
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    check_eq("t5_gnt", 32'(gnt), 32'h0);
    check_eq("t5_tout", 32'(tout), 32'h0);

    // 6: reset while busy, then first pick is requester 0
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0101, 1'b0, 1'b1);
    check_eq("t6_gnt", 32'(gnt), 32'h0);
    check_eq("t6_sel", 32'(sel), 32'h0);
    check_eq("t6_valid", 32'(valid), 32'h0);
    cyc(4'b0101, 1'b0, 1'b0);
    check_eq("t6_pick0", 32'(gnt), 32'h1);

    // Randomized traffic with sticky requests; phases vary done frequency
    cur = 4'b0;
    for (int i = 0; i < 4000; i++) begin
      phase = (i / 500) % 3;
      for (int b = 0; b < 4; b++) begin
        if (cur[b]) begin
          if ($urandom_range(phase == 2 ? 63 : 19) == 0) cur[b] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          cur[b] = 1'b1;
        end
      end
      cyc(cur,
          (phase == 0) ? ($urandom_range(7) == 0) :
          (phase == 1) ? ($urandom_range(39) == 0) : 1'b0,
          $urandom_range(299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
